// File: rtl/traced_ram_pkg.sv
// Shared types and constants for traced_word_ram: the write-log entry layout
// and the fixed word/overflow widths.
package traced_ram_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int OVF_WIDTH    = 16;
  localparam int LOG_ADDR_MAX = 32;

  // addr is stored at its widest; the top trims it to ADDR_WIDTH on output.
  typedef struct packed {
    logic [LOG_ADDR_MAX-1:0]   addr;
    logic [31:0]               data;
    logic [WORD_BYTES-1:0]     strb;
  } log_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with exact occupancy count.
// Pushing while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // At full, a simultaneous pop frees the head slot that this push reuses.
  assign do_push = push && !clear && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/traced_word_ram.sv
// Word RAM with a read/write data port, a read-only instruction port and a
// windowed write log. Define RAM_WR_FWD_EN for write-first same-word reads.
module traced_word_ram
  import traced_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter     SOURCE_FILE  = "",
  parameter int READ_LATENCY = 1,
  parameter int LOG_DEPTH    = 16,
  parameter int LOG_BASE     = 0,
  parameter int LOG_MASK     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     addr_1,
  input  logic [31:0]               wdata_1,
  input  logic [3:0]                wenable_1,
  output logic [31:0]               rdata_1,
  input  logic [ADDR_WIDTH-1:0]     addr_2,
  output logic [31:0]               rdata_2,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [ADDR_WIDTH-1:0]     log_addr,
  output logic [31:0]               log_data,
  output logic [3:0]                log_strb,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic [OVF_WIDTH-1:0]      log_overflow,
  input  logic                      log_clear
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** WA;

  logic [31:0]   mem [WORDS];
  logic [WA-1:0] wa_1;
  logic [WA-1:0] ra_2;

  assign wa_1 = addr_1[ADDR_WIDTH-1:2];
  assign ra_2 = addr_2[ADDR_WIDTH-1:2];

  // Memory writes are independent of reset so a reset-cycle write still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wenable_1[i]) mem[wa_1][8*i +: 8] <= wdata_1[8*i +: 8];
    end
  end

  if (READ_LATENCY == 1) begin : g_reg_read
    logic [31:0] rd1_word;
    logic [31:0] rd2_word;

    always_comb begin
      rd1_word = mem[wa_1];
      rd2_word = mem[ra_2];
`ifdef RAM_WR_FWD_EN
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wenable_1[i]) begin
          rd1_word[8*i +: 8] = wdata_1[8*i +: 8];
          if (ra_2 == wa_1) rd2_word[8*i +: 8] = wdata_1[8*i +: 8];
        end
      end
`endif
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_1 <= '0;
        rdata_2 <= '0;
      end else begin
        rdata_1 <= rd1_word;
        rdata_2 <= rd2_word;
      end
    end
  end else if (READ_LATENCY == 0) begin : g_comb_read
    assign rdata_1 = mem[wa_1];
    assign rdata_2 = mem[ra_2];
  end else begin : g_bad_latency
    $error("traced_word_ram: READ_LATENCY must be 0 or 1");
  end

  // Write log
  log_entry_t  push_entry;
  log_entry_t  head_entry;
  logic        log_match;
  logic        log_push;
  logic        log_pop;
  logic        log_full;
  logic        log_empty;

  assign log_match = ((addr_1 & ADDR_WIDTH'(LOG_MASK)) == ADDR_WIDTH'(LOG_BASE));
  assign log_push  = (|wenable_1) && log_match && rst_n && !log_clear;
  assign log_valid = !log_empty;
  assign log_pop   = log_valid && log_ready;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = LOG_ADDR_MAX'({wa_1, 2'b00});
    push_entry.data = wdata_1;
    push_entry.strb = wenable_1;
  end

  sync_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (log_push),
    .pop   (log_pop),
    .clear (log_clear),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (log_full),
    .empty (log_empty),
    .count (log_count)
  );

  assign log_addr = head_entry.addr[ADDR_WIDTH-1:0];
  assign log_data = head_entry.data;
  assign log_strb = head_entry.strb;

  // A push into a full log with no pop to make room is dropped and counted.
  always_ff @(posedge clk) begin
    if (!rst_n || log_clear) begin
      log_overflow <= '0;
    end else if (log_push && log_full && !log_pop && (log_overflow != '1)) begin
      log_overflow <= log_overflow + 1'b1;
    end
  end

  logic unused_bits;
  if (ADDR_WIDTH < LOG_ADDR_MAX) begin : g_unused_hi
    assign unused_bits = ^{addr_1[1:0], addr_2[1:0], head_entry.addr[LOG_ADDR_MAX-1:ADDR_WIDTH]};
  end else begin : g_unused_lo
    assign unused_bits = ^{addr_1[1:0], addr_2[1:0]};
  end

endmodule

// File: tb/tb_traced_word_ram.sv
// Self-checking bench for traced_word_ram: directed scenarios followed by
// randomized traffic checked against a word-array and queue reference model.
module tb_traced_word_ram;

  localparam int AW = 14;
  localparam int LD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr_1;
  logic [31:0] wdata_1;
  logic [3:0]  wenable_1;
  logic [31:0] rdata_1;
  logic [13:0] addr_2;
  logic [31:0] rdata_2;
  logic        log_valid;
  logic        log_ready;
  logic [13:0] log_addr;
  logic [31:0] log_data;
  logic [3:0]  log_strb;
  logic [2:0]  log_count;
  logic [15:0] log_overflow;
  logic        log_clear;

  always #5 clk = ~clk;

  traced_word_ram #(
    .ADDR_WIDTH   (AW),
    .SOURCE_FILE  (""),
    .READ_LATENCY (1),
    .LOG_DEPTH    (LD),
    .LOG_BASE     ('h3F00),
    .LOG_MASK     ('h3F00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_1       (addr_1),
    .wdata_1      (wdata_1),
    .wenable_1    (wenable_1),
    .rdata_1      (rdata_1),
    .addr_2       (addr_2),
    .rdata_2      (rdata_2),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_strb     (log_strb),
    .log_count    (log_count),
    .log_overflow (log_overflow),
    .log_clear    (log_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word array with known-flags, log as a queue of {addr,data,strb}.
  logic [31:0] mm [0:4095];
  bit          mk [0:4095];
  logic [49:0] exp_q[$];
  int          exp_ovf;
  logic [31:0] exp_rd1, exp_rd2;
  bit          rd1_k, rd2_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_edge();
    int          w1, w2;
    logic [31:0] nw;
    bit          pop, push, full;
    w1 = int'(addr_1[13:2]);
    w2 = int'(addr_2[13:2]);
    nw = merge(mm[w1], wdata_1, wenable_1);
    if (!rst_n) begin
      exp_rd1 = 0; exp_rd2 = 0; rd1_k = 1; rd2_k = 1;
    end else begin
`ifdef RAM_WR_FWD_EN
      exp_rd1 = nw;
      rd1_k   = mk[w1] || (wenable_1 == 4'hF);
      exp_rd2 = (w2 == w1) ? nw : mm[w2];
      rd2_k   = (w2 == w1) ? rd1_k : mk[w2];
`else
      exp_rd1 = mm[w1]; rd1_k = mk[w1];
      exp_rd2 = mm[w2]; rd2_k = mk[w2];
`endif
    end
    pop  = (exp_q.size() > 0) && log_ready;
    push = (wenable_1 != 0) && ((addr_1 & 14'h3F00) == 14'h3F00) && rst_n && !log_clear;
    if (!rst_n || log_clear) begin
      exp_q.delete();
      exp_ovf = 0;
    end else begin
      full = (exp_q.size() == LD);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (full && !pop) begin
          if (exp_ovf < 65535) exp_ovf++;
        end else begin
          exp_q.push_back({addr_1[13:2], 2'b00, wdata_1, wenable_1});
        end
      end
    end
    mm[w1] = nw;
    mk[w1] = mk[w1] || (wenable_1 == 4'hF);
  endtask

  task automatic check_all();
    logic [49:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 50'd0;
    if (rd1_k) chk("rdata_1", rdata_1, exp_rd1);
    if (rd2_k) chk("rdata_2", rdata_2, exp_rd2);
    chk("log_valid", 32'(log_valid), 32'(exp_q.size() > 0));
    chk("log_count", 32'(log_count), 32'(exp_q.size()));
    chk("log_overflow", 32'(log_overflow), 32'(exp_ovf));
    chk("log_addr", 32'(log_addr), 32'(head[49:36]));
    chk("log_data", log_data, head[35:4]);
    chk("log_strb", 32'(log_strb), 32'(head[3:0]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] en);
    addr_1 = a; wdata_1 = d; wenable_1 = en;
    step();
  endtask

  function automatic logic [13:0] pick();
    int w;
    w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : 'hFC0 + int'($urandom_range(0, 15));
    return {w[11:0], 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin mm[i] = 'x; mk[i] = 0; end
    exp_ovf = 0;
    rst_n = 0; addr_1 = 0; wdata_1 = 0; wenable_1 = 0; addr_2 = 0;
    log_ready = 0; log_clear = 0;

    // Reset state
    step();
    step();
    chk("rst_rdata_1", rdata_1, 32'h0);
    chk("rst_rdata_2", rdata_2, 32'h0);
    rst_n = 1;

    // Zero the regions used below; log_clear keeps init writes out of the log
    log_clear = 1;
    for (int i = 0; i < 64; i++) wr(14'(i * 4), 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) wr(14'('h3F00 + i * 4), 32'h0, 4'hF);
    log_clear = 0;

    // Basic write then instruction-port read
    wr(14'h0010, 32'hDEADBEEF, 4'hF);
    wenable_1 = 0; addr_2 = 14'h0010;
    step();
    chk("port2_read", rdata_2, 32'hDEADBEEF);

    // Byte-lane merge
    wr(14'h0020, 32'hAABBCCDD, 4'hF);
    wr(14'h0020, 32'h11223344, 4'b0101);
    wenable_1 = 0;
    step();
    chk("lane_merge", rdata_1, 32'hAA22CC44);

    // Same-cycle same-word collision on port 2
    addr_2 = 14'h0030;
    wr(14'h0030, 32'h12345678, 4'hF);
`ifdef RAM_WR_FWD_EN
    chk("collision", rdata_2, 32'h12345678);
`else
    chk("collision", rdata_2, 32'h0);
`endif
    wenable_1 = 0;
    step();
    chk("after_collision", rdata_2, 32'h12345678);

    // Window filtering
    wr(14'h3F04, 32'hA5A50001, 4'b0011);
    wr(14'h0100, 32'h5A5A0002, 4'hF);
    wenable_1 = 0;
    step();
    chk("win_count", 32'(log_count), 32'd1);
    chk("win_addr", 32'(log_addr), 32'h3F04);
    chk("win_data", log_data, 32'hA5A50001);
    chk("win_strb", 32'(log_strb), 32'h3);

    // Fill, overflow, then push+pop at full
    log_clear = 1; step(); log_clear = 0;
    for (int i = 0; i < 6; i++) wr(14'(14'h3F08 + i * 4), 32'(32'hC0DE0000 + i), 4'hF);
    wenable_1 = 0;
    step();
    chk("full_count", 32'(log_count), 32'd4);
    chk("full_ovf", 32'(log_overflow), 32'd2);
    log_ready = 1;
    wr(14'h3F20, 32'hFEEDF00D, 4'hF);
    chk("pushpop_count", 32'(log_count), 32'd4);
    chk("pushpop_ovf", 32'(log_overflow), 32'd2);
    log_ready = 0; wenable_1 = 0;

    // Clear with a same-cycle in-window write
    log_clear = 1;
    wr(14'h3F24, 32'h0BADCAFE, 4'hF);
    chk("clear_count", 32'(log_count), 32'd0);
    chk("clear_ovf", 32'(log_overflow), 32'd0);
    chk("clear_valid", 32'(log_valid), 32'd0);
    log_clear = 0; wenable_1 = 0;
    step();
    chk("clear_mem", rdata_1, 32'h0BADCAFE);

    // Reset mid-operation: write lands, log empties, entry not logged
    wr(14'h3F2C, 32'h11111111, 4'hF);
    rst_n = 0;
    wr(14'h3F28, 32'h600DF00D, 4'hF);
    chk("rstwr_count", 32'(log_count), 32'd0);
    rst_n = 1; wenable_1 = 0;
    step();
    chk("rstwr_mem", rdata_1, 32'h600DF00D);
    chk("rstwr_nolog", 32'(log_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      log_clear = ($urandom_range(0, 59) == 0);
      log_ready = ($urandom_range(0, 2) == 0);
      addr_1    = pick();
      addr_2    = pick();
      wdata_1   = $urandom;
      wenable_1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
